if_id_queue: RTL and testbench
==============================

Name: if_id_queue

Overview:
- Small instruction queue between the fetch stage and the decode stage.
- Captures {next_pc, inst} pairs produced by fetch each cycle and presents them to decode through a valid/ready handshake.
- Back-pressures fetch when full. Discards all queued entries on a taken branch/jump (flush).
- Presents a MIPS NOP (32'h00000000) to decode whenever empty.

Parameters:
- ADDR_W, 32, width of next_pc field (matches instruction address bus).
- INST_W, 32, width of instruction field (matches instruction bus).
- DEPTH, 2, number of entries; power of two, >= 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  taken branch/jump resolved downstream; squash all entries this cycle.
- if_valid  in  1  fetch presents a valid instruction this cycle.
- if_next_pc  in  ADDR_W  PC+4 of the fetched instruction.
- if_inst  in  INST_W  fetched instruction word.
- if_ready  out  1  queue can accept a push this cycle; fetch holds PC when low.
- id_ready  in  1  decode consumes the head entry this cycle.
- id_valid  out  1  head entry valid.
- id_next_pc  out  ADDR_W  head entry PC+4; 0 when empty.
- id_inst  out  INST_W  head entry instruction; 32'h0 (NOP) when empty.
- count  out  clog2(DEPTH)+1  current occupancy.

Behaviour:
- Storage: circular buffer of DEPTH entries, each {next_pc, inst}, with wr_ptr and rd_ptr of clog2(DEPTH) bits that wrap modulo DEPTH. Occupancy is held in the count register.
- Reset (rst=1 at clock edge): wr_ptr=0, rd_ptr=0, count=0.
  - Hence id_valid=0, id_next_pc=0, id_inst=0, if_ready=1 in the cycle after reset.
  - Storage array is not reset.
  - Reset mid-operation discards all entries identically to flush.
- Combinational outputs:
  - if_ready = (count != DEPTH). There is no push-through-when-full, even if a pop occurs the same cycle.
  - id_valid = (count != 0).
  - id_next_pc/id_inst = head entry when id_valid, else zero.
- Qualified events:
  - push = if_valid & if_ready & ~flush.
  - pop = id_valid & id_ready & ~flush.
- Clock edge, priority rst > flush > push/pop:
  - flush=1: wr_ptr=rd_ptr=0, count=0. Any same-cycle push is dropped and pop is ignored. id_valid=0 the next cycle.
  - push only: write entry at wr_ptr, wr_ptr+1, count+1.
  - pop only: rd_ptr+1, count-1.
  - push & pop: write at wr_ptr, both pointers advance, count unchanged.
- Latency:
  - A word pushed at edge N is visible on id_* after edge N (one-cycle latency).
  - No combinational bypass from if_* to id_*, so an empty queue always shows a NOP bubble for one cycle.
- Ordering: strict FIFO.
- Boundaries:
  - count never exceeds DEPTH and never underflows; pop when empty is impossible by construction.
  - Pointer wrap from DEPTH-1 to 0 is seamless.
- id_ready while id_valid=0 has no effect. if_valid while if_ready=0 has no effect; fetch must hold its PC.

Test Plan:
- Reset then fill:
  - Stimulus: rst=1 for 2 cycles, then push (next_pc=0x4, inst=0x24080001) with id_ready=0.
  - Response: after reset id_valid=0, id_inst=0, if_ready=1. One cycle later id_valid=1, id_next_pc=0x4, id_inst=0x24080001, count=1.
- Full/back-pressure:
  - Stimulus: push 0x4/0xA and 0x8/0xB with id_ready=0.
  - Response: count=2, if_ready=0. A third push (0xC/0xC) is ignored. Then pop with id_ready=1 for 2 cycles yields 0xA then 0xB, followed by id_valid=0, id_inst=0.
- Simultaneous push/pop:
  - Stimulus: with count=1 (head 0xA), push 0xB and pop in the same cycle.
  - Response: count stays 1, head becomes 0xB.
  - Repeat for 5 cycles with incrementing words: pointer wrap, order preserved.
- Flush priority:
  - Stimulus: with count=2, assert flush together with if_valid=1 and id_ready=1.
  - Response: next cycle count=0, id_valid=0, if_ready=1. The pushed word never appears.
- Reset mid-operation:
  - Stimulus: with count=2, assert rst together with if_valid=1.
  - Response: next cycle count=0, id_next_pc=0, id_inst=0. A subsequent push 0x10/0x1234 appears one cycle later as the sole entry.

Source files
------------

// File: rtl/if_id_queue_if.sv
// Fetch/decode handshake bundle for the IF/ID instruction queue.
// The master side is the pipeline (fetch + decode) and the slave side is the queue.
interface if_id_queue_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 2
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              flush;
  logic              if_valid;
  logic [ADDR_W-1:0] if_next_pc;
  logic [INST_W-1:0] if_inst;
  logic              if_ready;
  logic              id_ready;
  logic              id_valid;
  logic [ADDR_W-1:0] id_next_pc;
  logic [INST_W-1:0] id_inst;
  logic [CNT_W-1:0]  count;

  modport master (
    output flush, if_valid, if_next_pc, if_inst, id_ready,
    input  if_ready, id_valid, id_next_pc, id_inst, count
  );

  modport slave (
    input  flush, if_valid, if_next_pc, if_inst, id_ready,
    output if_ready, id_valid, id_next_pc, id_inst, count
  );
endinterface

// File: rtl/if_id_queue.sv
// Circular-buffer instruction queue between fetch and decode.
// Shows a NOP (all zero) to decode whenever it is empty; flush squashes every entry.
module if_id_queue #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic         clk,
  input  logic         rst,
  if_id_queue_if.slave q
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;

  logic not_full;
  logic not_empty;
  logic push;
  logic pop;

  assign not_full  = (count_q != FULL);
  assign not_empty = (count_q != '0);

  // No push-through when full: a same-cycle pop does not open a slot.
  assign push = q.if_valid & not_full  & ~q.flush;
  assign pop  = q.id_ready & not_empty & ~q.flush;

  assign q.if_ready   = not_full;
  assign q.id_valid   = not_empty;
  assign q.id_next_pc = not_empty ? pc_mem[rd_ptr]   : '0;
  assign q.id_inst    = not_empty ? inst_mem[rd_ptr] : '0;
  assign q.count      = count_q;

  always_ff @(posedge clk) begin
    if (rst || q.flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)
        count_q <= count_q + CNT_W'(1);
      else if (pop && !push)
        count_q <= count_q - CNT_W'(1);
    end
  end

  // Storage is left unreset; a write during reset is harmless since the pointers clear.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= q.if_next_pc;
      inst_mem[wr_ptr] <= q.if_inst;
    end
  end
endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: directed test-plan steps then random traffic,
// all checked against a queue-based reference model.
module tb_if_id_queue;
  localparam int DEPTH = 2;

  logic clk;
  logic rst;

  if_id_queue_if #(.ADDR_W(32), .INST_W(32), .DEPTH(DEPTH)) bus ();

  if_id_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .q   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t mq[$];
  int n_cmp;
  int n_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    e_pc   = (mq.size() != 0) ? mq[0].pc   : 32'h0;
    e_inst = (mq.size() != 0) ? mq[0].inst : 32'h0;
    check({tag, ".count"},    32'(bus.count),    32'(mq.size()));
    check({tag, ".id_valid"}, 32'(bus.id_valid), 32'(mq.size() != 0));
    check({tag, ".if_ready"}, 32'(bus.if_ready), 32'(mq.size() < DEPTH));
    check({tag, ".id_pc"},    bus.id_next_pc,    e_pc);
    check({tag, ".id_inst"},  bus.id_inst,       e_inst);
  endtask

  // Apply inputs for one cycle, clock it, update the model, then check outputs.
  task automatic step(input string tag, input logic r, input logic f, input logic v,
                      input logic [31:0] pc, input logic [31:0] inst, input logic rdy);
    entry_t e;
    bit do_push;
    bit do_pop;
    rst            = r;
    bus.flush      = f;
    bus.if_valid   = v;
    bus.if_next_pc = pc;
    bus.if_inst    = inst;
    bus.id_ready   = rdy;
    do_push = v && (mq.size() < DEPTH);
    do_pop  = rdy && (mq.size() != 0);
    @(posedge clk);
    #1;
    if (r || f) begin
      mq.delete();
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        e.pc   = pc;
        e.inst = inst;
        mq.push_back(e);
      end
    end
    check_all(tag);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.if_valid = 1'b0;
    bus.if_next_pc = '0;
    bus.if_inst = '0;
    bus.id_ready = 1'b0;
    #2;

    // Reset then fill
    step("rst0", 1, 0, 0, 0, 0, 0);
    step("rst1", 1, 0, 0, 0, 0, 0);
    check("rst.if_ready", 32'(bus.if_ready), 32'd1);
    step("fill", 0, 0, 1, 32'h4, 32'h24080001, 0);
    check("fill.inst", bus.id_inst, 32'h24080001);
    check("fill.count", 32'(bus.count), 32'd1);

    // Full / back-pressure
    step("bp.rst", 1, 0, 0, 0, 0, 0);
    step("bp.a", 0, 0, 1, 32'h4, 32'hA, 0);
    step("bp.b", 0, 0, 1, 32'h8, 32'hB, 0);
    check("bp.full", 32'(bus.if_ready), 32'd0);
    step("bp.c", 0, 0, 1, 32'hC, 32'hC, 0);
    check("bp.c_ignored", 32'(bus.count), 32'd2);
    step("bp.pop1", 0, 0, 0, 0, 0, 1);
    check("bp.head_b", bus.id_inst, 32'hB);
    step("bp.pop2", 0, 0, 0, 0, 0, 1);
    check("bp.empty_nop", bus.id_inst, 32'h0);

    // Simultaneous push/pop with pointer wrap
    step("pp.a", 0, 0, 1, 32'h4, 32'hA, 0);
    for (int i = 0; i < 5; i++) begin
      step("pp", 0, 0, 1, 32'h8 + 32'(4 * i), 32'hB + 32'(i), 1);
      check("pp.head", bus.id_inst, 32'hB + 32'(i));
    end

    // Flush priority over push and pop
    step("fl.x", 0, 0, 1, 32'h20, 32'h77, 0);
    check("fl.full", 32'(bus.count), 32'd2);
    step("fl.flush", 0, 1, 1, 32'h24, 32'hDEAD, 1);
    step("fl.idle", 0, 0, 0, 0, 0, 0);
    check("fl.gone", 32'(bus.id_valid), 32'd0);

    // Reset mid-operation
    step("rm.a", 0, 0, 1, 32'h4, 32'h1, 0);
    step("rm.b", 0, 0, 1, 32'h8, 32'h2, 0);
    step("rm.rst", 1, 0, 1, 32'hC, 32'h3, 0);
    step("rm.push", 0, 0, 1, 32'h10, 32'h1234, 0);
    check("rm.sole_pc", bus.id_next_pc, 32'h10);
    check("rm.sole_cnt", 32'(bus.count), 32'd1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step("rnd",
           ($urandom_range(99) < 2),
           ($urandom_range(99) < 6),
           ($urandom_range(99) < 70),
           $urandom, $urandom,
           ($urandom_range(99) < 55));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
